alarm_ring_ctrl: RTL and testbench
==================================

// Module: alarm_ring_ctrl
// PURPOSE
//  Sequences the alarm: compares the armed 52-bit alarm word from the alarm-setting mode with the running
//  clock time, drives the ringing and buzzer outputs, and handles dismiss, snooze and ring timeout.
//  Sits between the alarm-setting mode, the timekeeping core and the buzzer/LCD status logic.
// PARAMETERS
//  RING_SEC    60   ring duration in tick_1s pulses before auto-dismiss (1..255)
//  SNOOZE_SEC  300  snooze interval in tick_1s pulses (1..1023)
//  SNOOZE_MAX  3    snoozes allowed per alarm event; further snooze presses are ignored
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous active-low reset
//  tick_1s    in   1   one-clk-wide pulse, once per second
//  sw_in      in   4   button code: 4'b0001 = dismiss, 4'b0010 = snooze; other codes are ignored
//  bin_alarm  in   52  {year[51:40],month[39:32],day[31:24],hour[23:16],minute[15:8],second[7:0]}; all-zero = no alarm
//  bin_now    in   52  current time, same packing
//  ringing    out  1   high in RINGING
//  buzzer     out  1   beep drive: ringing & phase
//  snoozing   out  1   high in SNOOZE
//  state      out  3   current FSM state, for LCD status
// BEHAVIOUR
//  Reset: the block has one clock; reset is synchronous and active-low. With rst=0 at a clk edge:
//   state=IDLE, ringing=0, buzzer=0, snoozing=0, all counters=0, alarm_q=0.
//   Reset takes priority over every other event, including mid-ring and mid-snooze.
//  States: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3, DONE=4.
//  Alarm capture: alarm_q is a registered copy of bin_alarm. A difference between bin_alarm and alarm_q in any
//   cycle is a change. On a change: load alarm_q. Next state is IDLE if bin_alarm==0, otherwise ARMED.
//   Counters are cleared. A change takes priority over every event except reset.
//  IDLE -> ARMED when alarm_q!=0 (this transition is reached only through a change).
//  ARMED -> RINGING on the cycle after bin_now==alarm_q (exact 52-bit match).
//   If the time steps over the alarm value, the alarm does not ring. Entering RINGING clears ring_cnt and sets phase=1.
//  Button edge: a press is recognised only on the first cycle in which sw_in equals a code (sw_prev != code).
//   Holding a button gives one action. sw_prev resets to 0.
//  RINGING:
//   - phase toggles on each tick_1s.
//   - ring_cnt increments on each tick_1s; when it reaches RING_SEC -> DONE.
//   - dismiss press -> DONE.
//   - snooze press with snooze_cnt<SNOOZE_MAX -> SNOOZE; snooze_cnt++ and snz_cnt=0.
//   - Same-cycle priority: dismiss > snooze > timeout.
//  SNOOZE:
//   - snz_cnt increments on each tick_1s; when it reaches SNOOZE_SEC -> RINGING (ring_cnt=0, phase=1).
//   - dismiss press -> DONE. Snooze presses are ignored.
//  DONE: outputs low. Stays until a change of bin_alarm, so the same alarm does not re-ring in the same second.
//   snooze_cnt clears on leaving DONE.
//  Widths: ring_cnt is 8 bits. snz_cnt is 10 bits. snooze_cnt is 2 bits and saturates at SNOOZE_MAX.
//  Outputs are registered with 1-clk latency from the state register; buzzer=0 outside RINGING.
// CONFIGURATION
//  ALARM_SNOOZE_EN defined: snooze behaves as above.
//  Not defined: the snooze code is ignored, SNOOZE is unreachable, snoozing is tied to 0,
//   and the snooze counters are not built.
// STRUCTURE
//  alarm_pkg: state encodings, SW_DISMISS/SW_SNOOZE codes, field bit offsets of the 52-bit time word.
//  Sub-module alarm_sec_timer:
//   - inputs clk, rst, clear, tick_1s, limit; output done.
//   - done goes high when the count reaches limit.
//   - Instantiated twice: once for ring timeout, once for snooze (snooze instance under ALARM_SNOOZE_EN).
//  FSM, change detect, match compare and button-edge logic stay in alarm_ring_ctrl.
// TESTING
//  1. Set bin_alarm=T, step bin_now to T -> ringing=1 one clk later; buzzer follows phase on each tick_1s.
//  2. Ring with no button, RING_SEC=60 -> DONE after the 60th tick_1s; ringing=0; bin_now=T again -> no re-ring.
//  3. Snooze at ring tick 5 -> snoozing=1; after 300 ticks -> ringing=1; the 4th snooze press is ignored (SNOOZE_MAX=3).
//  4. Dismiss and snooze in the same cycle, and dismiss on the same cycle as the 60th tick_1s -> DONE.
//  5. rst=0 mid-RINGING -> state=IDLE and all outputs 0 at the next edge.
//     bin_alarm=0 mid-SNOOZE -> IDLE.
//  6. Build without ALARM_SNOOZE_EN; press snooze while ringing -> still RINGING, snoozing=0 throughout.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared encodings for the alarm sequencer: FSM states, button codes and the
// layout of the 52-bit packed time word.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RINGING = 3'd2,
    ST_SNOOZE  = 3'd3,
    ST_DONE    = 3'd4
  } alarm_state_e;

  localparam logic [3:0] SW_DISMISS = 4'b0001;
  localparam logic [3:0] SW_SNOOZE  = 4'b0010;

  localparam int TIME_W       = 52;
  localparam int RING_CNT_W   = 8;
  localparam int SNZ_CNT_W    = 10;
  localparam int SNOOZE_CNT_W = 2;

  // Field layout of the time word, MSB first: year[51:40] .. second[7:0].
  typedef struct packed {
    logic [11:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  second;
  } time_t;

  // True only on the first cycle a button code appears.
  function automatic logic btn_edge(input logic [3:0] sw, input logic [3:0] prev,
                                    input logic [3:0] code);
    return (sw == code) && (prev != code);
  endfunction

endpackage

// File: rtl/alarm_sec_timer.sv
// Seconds counter: counts tick_1s pulses while not cleared and flags the tick
// on which the count reaches limit.
module alarm_sec_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         tick_1s,
  input  logic [W-1:0] limit,
  output logic         done
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick_1s) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Combinational on the tick itself so timeout can be arbitrated against a same-cycle button.
  assign done = tick_1s && !clear && ((cnt_q + ONE) == limit);

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencer: arms on a new alarm word, rings on an exact time match, and
// handles dismiss, snooze and ring timeout. Snooze is built only with ALARM_SNOOZE_EN.
module alarm_ring_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int SNOOZE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1s,
  input  logic [3:0]        sw_in,
  input  logic [TIME_W-1:0] bin_alarm,
  input  logic [TIME_W-1:0] bin_now,
  output logic              ringing,
  output logic              buzzer,
  output logic              snoozing,
  output logic [2:0]        state
);

  if (RING_SEC < 1 || RING_SEC > 255) begin : g_bad_ring_sec
    $error("RING_SEC must be in 1..255");
  end
  if (SNOOZE_SEC < 1 || SNOOZE_SEC > 1023) begin : g_bad_snooze_sec
    $error("SNOOZE_SEC must be in 1..1023");
  end
  if (SNOOZE_MAX < 1 || SNOOZE_MAX > 3) begin : g_bad_snooze_max
    $error("SNOOZE_MAX must be in 1..3");
  end

  localparam logic [RING_CNT_W-1:0] RING_LIM = RING_CNT_W'(RING_SEC);

  alarm_state_e      state_q, state_d;
  logic [TIME_W-1:0] alarm_q;
  logic [3:0]        sw_prev_q;
  logic              phase_q, phase_d;
  logic              ringing_q, buzzer_q;

  logic change, match, dismiss_press, ring_done;

  assign change        = (bin_alarm != alarm_q);
  assign match         = (bin_now == alarm_q);
  assign dismiss_press = btn_edge(sw_in, sw_prev_q, SW_DISMISS);

  alarm_sec_timer #(.W(RING_CNT_W)) u_ring_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (change || (state_q != ST_RINGING)),
    .tick_1s (tick_1s),
    .limit   (RING_LIM),
    .done    (ring_done)
  );

`ifdef ALARM_SNOOZE_EN
  localparam logic [SNZ_CNT_W-1:0]    SNZ_LIM = SNZ_CNT_W'(SNOOZE_SEC);
  localparam logic [SNOOZE_CNT_W-1:0] SNZ_MAX = SNOOZE_CNT_W'(SNOOZE_MAX);
  localparam logic [SNOOZE_CNT_W-1:0] SNZ_ONE = SNOOZE_CNT_W'(1);

  logic [SNOOZE_CNT_W-1:0] snooze_cnt_q, snooze_cnt_d;
  logic                    snoozing_q;
  logic                    snooze_press, snz_done;

  assign snooze_press = btn_edge(sw_in, sw_prev_q, SW_SNOOZE);

  alarm_sec_timer #(.W(SNZ_CNT_W)) u_snz_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (change || (state_q != ST_SNOOZE)),
    .tick_1s (tick_1s),
    .limit   (SNZ_LIM),
    .done    (snz_done)
  );
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
`ifdef ALARM_SNOOZE_EN
    snooze_cnt_d = snooze_cnt_q;
`endif
    // A new alarm word overrides whatever the sequence was doing.
    if (change) begin
      state_d = (bin_alarm == '0) ? ST_IDLE : ST_ARMED;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (alarm_q != '0) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (match) state_d = ST_RINGING;
        end
        ST_RINGING: begin
          if (dismiss_press) begin
            state_d = ST_DONE;
          end
`ifdef ALARM_SNOOZE_EN
          else if (snooze_press && (snooze_cnt_q < SNZ_MAX)) begin
            state_d      = ST_SNOOZE;
            snooze_cnt_d = snooze_cnt_q + SNZ_ONE;
          end
`endif
          else if (ring_done) begin
            state_d = ST_DONE;
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (dismiss_press) begin
            state_d = ST_DONE;
          end else if (snz_done) begin
            state_d = ST_RINGING;
          end
        end
`endif
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Every ring burst starts with the buzzer on.
    if ((state_d == ST_RINGING) && (state_q != ST_RINGING)) begin
      phase_d = 1'b1;
    end else if ((state_q == ST_RINGING) && tick_1s) begin
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      alarm_q   <= '0;
      sw_prev_q <= '0;
      phase_q   <= 1'b0;
      ringing_q <= 1'b0;
      buzzer_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sw_prev_q <= sw_in;
      phase_q   <= phase_d;
      ringing_q <= (state_q == ST_RINGING);
      buzzer_q  <= (state_q == ST_RINGING) && phase_q;
      if (change) alarm_q <= bin_alarm;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      snooze_cnt_q <= '0;
      snoozing_q   <= 1'b0;
    end else begin
      snooze_cnt_q <= snooze_cnt_d;
      snoozing_q   <= (state_q == ST_SNOOZE);
    end
  end
  assign snoozing = snoozing_q;
`else
  assign snoozing = 1'b0;
`endif

  assign ringing = ringing_q;
  assign buzzer  = buzzer_q;
  assign state   = state_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Bench for alarm_ring_ctrl: fixed vector table, hand-written corner sequences
// and a randomized run against a behavioural model of the alarm rules.
module tb_alarm_ring_ctrl;

  localparam int RING_SEC   = 60;
  localparam int SNOOZE_SEC = 300;
  localparam int SNOOZE_MAX = 3;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  localparam int S_IDLE = 0, S_ARMED = 1, S_RING = 2, S_SNZ = 3, S_DONE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_1s = 1'b0;
  logic [3:0]  sw_in = 4'd0;
  logic [51:0] bin_alarm = '0;
  logic [51:0] bin_now = '0;
  logic        ringing, buzzer, snoozing;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alarm_ring_ctrl #(
    .RING_SEC   (RING_SEC),
    .SNOOZE_SEC (SNOOZE_SEC),
    .SNOOZE_MAX (SNOOZE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1s   (tick_1s),
    .sw_in     (sw_in),
    .bin_alarm (bin_alarm),
    .bin_now   (bin_now),
    .ringing   (ringing),
    .buzzer    (buzzer),
    .snoozing  (snoozing),
    .state     (state)
  );

  // Behavioural model: alarm rules with plain integer counters.
  int          m_state = 0;
  logic [51:0] m_alarm = '0;
  int          m_ring = 0, m_snz = 0, m_scnt = 0;
  bit          m_phase = 1'b0;
  logic [3:0]  m_prev = 4'd0;
  bit          m_ringing = 1'b0, m_buzzer = 1'b0, m_snoozing = 1'b0;

  task automatic model_edge();
    bit dis, snz, nr, nb, nsz;
    int ns;
    nr  = (m_state == S_RING);
    nb  = nr && m_phase;
    nsz = (m_state == S_SNZ);
    if (!rst) begin
      m_state = S_IDLE; m_alarm = '0; m_ring = 0; m_snz = 0; m_scnt = 0;
      m_phase = 1'b0; m_prev = 4'd0;
      m_ringing = 1'b0; m_buzzer = 1'b0; m_snoozing = 1'b0;
      return;
    end
    dis = (sw_in == 4'b0001) && (m_prev != 4'b0001);
    snz = SNZ_EN && (sw_in == 4'b0010) && (m_prev != 4'b0010);
    ns  = m_state;
    if (bin_alarm != m_alarm) begin
      m_alarm = bin_alarm;
      ns = (bin_alarm == '0) ? S_IDLE : S_ARMED;
      m_ring = 0; m_snz = 0; m_scnt = 0;
    end else begin
      case (m_state)
        S_IDLE:  if (m_alarm != '0) ns = S_ARMED;
        S_ARMED: if (bin_now == m_alarm) begin ns = S_RING; m_ring = 0; m_phase = 1'b1; end
        S_RING: begin
          if (tick_1s) begin m_ring++; m_phase = !m_phase; end
          if (dis) ns = S_DONE;
          else if (snz && m_scnt < SNOOZE_MAX) begin ns = S_SNZ; m_scnt++; m_snz = 0; end
          else if (tick_1s && m_ring >= RING_SEC) ns = S_DONE;
        end
        S_SNZ: begin
          if (tick_1s) m_snz++;
          if (dis) ns = S_DONE;
          else if (tick_1s && m_snz >= SNOOZE_SEC) begin ns = S_RING; m_ring = 0; m_phase = 1'b1; end
        end
        default: ;
      endcase
    end
    m_state = ns; m_prev = sw_in;
    m_ringing = nr; m_buzzer = nb; m_snoozing = nsz;
  endtask

  task automatic check_out(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%0d r=%0b b=%0b s=%0b, required st=%0d r=%0b b=%0b s=%0b",
               name, act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // One clock: model and DUT see the same inputs, outputs compared #1 after the edge.
  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check_out(name, {state, ringing, buzzer, snoozing},
              {3'(m_state), m_ringing, m_buzzer, m_snoozing});
  endtask

  task automatic do_reset();
    rst = 1'b0; tick_1s = 1'b0; sw_in = 4'd0;
    step("reset");
    rst = 1'b1;
  endtask

  task automatic arm_and_ring(input logic [51:0] t);
    bin_alarm = t; bin_now = t - 52'd1;
    step("arm");
    bin_now = t;
    step("match");
    bin_now = t + 52'd1;
  endtask

  task automatic tick_pulse(input string name);
    tick_1s = 1'b1; step(name);
    tick_1s = 1'b0; step(name);
  endtask

  typedef struct {
    bit          rst;
    bit          tick;
    logic [3:0]  sw;
    logic [51:0] alarm;
    logic [51:0] now;
    logic [5:0]  exp;   // {state, ringing, buzzer, snoozing}
  } vec_t;

  localparam logic [51:0] T = 52'h7E8_0C_1F_17_3B_00;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 4'd0, 52'd0, 52'd0,    {3'd0, 3'b000}};
    vecs[1]  = '{1'b1, 1'b0, 4'd0, T,     T - 2,    {3'd1, 3'b000}};
    vecs[2]  = '{1'b1, 1'b0, 4'd0, T,     T - 1,    {3'd1, 3'b000}};
    vecs[3]  = '{1'b1, 1'b0, 4'd0, T,     T,        {3'd2, 3'b000}};
    vecs[4]  = '{1'b1, 1'b0, 4'd0, T,     T + 1,    {3'd2, 3'b110}};
    vecs[5]  = '{1'b1, 1'b1, 4'd0, T,     T + 1,    {3'd2, 3'b110}};
    vecs[6]  = '{1'b1, 1'b0, 4'd0, T,     T + 1,    {3'd2, 3'b100}};
    vecs[7]  = '{1'b1, 1'b1, 4'd0, T,     T + 2,    {3'd2, 3'b100}};
    vecs[8]  = '{1'b1, 1'b0, 4'd0, T,     T + 2,    {3'd2, 3'b110}};
    vecs[9]  = '{1'b1, 1'b0, 4'd1, T,     T + 2,    {3'd4, 3'b110}};
    vecs[10] = '{1'b1, 1'b0, 4'd1, T,     T + 2,    {3'd4, 3'b000}};
    vecs[11] = '{1'b1, 1'b0, 4'd0, T,     T,        {3'd4, 3'b000}};
    vecs[12] = '{1'b1, 1'b0, 4'd0, 52'd0, T,        {3'd0, 3'b000}};
    vecs[13] = '{1'b1, 1'b0, 4'd0, T,     T - 5,    {3'd1, 3'b000}};
    vecs[14] = '{1'b1, 1'b0, 4'd0, T,     T,        {3'd2, 3'b000}};
    vecs[15] = '{1'b1, 1'b0, 4'd0, T,     T,        {3'd2, 3'b110}};
    vecs[16] = '{1'b0, 1'b0, 4'd0, T,     T,        {3'd0, 3'b000}};
    vecs[17] = '{1'b1, 1'b0, 4'd0, T,     T + 1,    {3'd1, 3'b000}};
    vecs[18] = '{1'b1, 1'b0, 4'd0, 52'd0, T + 1,    {3'd0, 3'b000}};

    for (int i = 0; i < 19; i++) begin
      rst = vecs[i].rst; tick_1s = vecs[i].tick; sw_in = vecs[i].sw;
      bin_alarm = vecs[i].alarm; bin_now = vecs[i].now;
      step("vec_model");
      check_out($sformatf("vec%0d", i), {state, ringing, buzzer, snoozing}, vecs[i].exp);
    end

    // Ring runs out after RING_SEC ticks and does not re-ring on the same time.
    do_reset();
    arm_and_ring(T);
    repeat (RING_SEC - 1) tick_pulse("ring_tick");
    check_val("ring_before_timeout", int'(state), S_RING);
    tick_1s = 1'b1; step("timeout_tick"); tick_1s = 1'b0;
    check_val("timeout_done", int'(state), S_DONE);
    step("timeout_after");
    check_val("timeout_ringing_off", int'(ringing), 0);
    bin_now = T;
    repeat (3) step("no_rering");
    check_val("no_rering_state", int'(state), S_DONE);

    // Unknown button code is ignored; dismiss afterwards still works.
    do_reset();
    arm_and_ring(T);
    sw_in = 4'b0011; step("code3"); step("code3");
    check_val("code_0011_ignored", int'(state), S_RING);
    sw_in = 4'b0001; step("dismiss");
    sw_in = 4'd0;
    check_val("dismiss_after_code3", int'(state), S_DONE);

    // Dismiss on the same cycle as the final ring tick.
    do_reset();
    arm_and_ring(T);
    repeat (RING_SEC - 1) tick_pulse("ring_tick2");
    tick_1s = 1'b1; sw_in = 4'b0001; step("dismiss_on_timeout");
    tick_1s = 1'b0; sw_in = 4'd0;
    check_val("dismiss_with_timeout", int'(state), S_DONE);

`ifdef ALARM_SNOOZE_EN
    do_reset();
    arm_and_ring(T);
    repeat (4) tick_pulse("pre_snooze");
    tick_1s = 1'b1; sw_in = 4'b0010; step("snooze_at_tick5");
    tick_1s = 1'b0; sw_in = 4'd0;
    check_val("snooze1_state", int'(state), S_SNZ);
    step("snooze1_out");
    check_val("snooze1_snoozing", int'(snoozing), 1);
    repeat (SNOOZE_SEC - 1) tick_pulse("snz_tick");
    check_val("snooze1_not_yet", int'(state), S_SNZ);
    tick_1s = 1'b1; step("snz_expire"); tick_1s = 1'b0;
    check_val("snooze1_expire", int'(state), S_RING);
    step("snz_expire_out");
    check_val("snooze1_ringing", int'(ringing), 1);
    for (int k = 2; k <= 3; k++) begin
      sw_in = 4'b0010; step("snz_press"); sw_in = 4'd0; step("snz_release");
      check_val($sformatf("snooze%0d_state", k), int'(state), S_SNZ);
      repeat (SNOOZE_SEC) tick_pulse("snz_tick");
      check_val($sformatf("snooze%0d_expire", k), int'(state), S_RING);
    end
    sw_in = 4'b0010; step("snz4_press"); sw_in = 4'd0; step("snz4_release");
    check_val("snooze4_ignored", int'(state), S_RING);
    check_val("snooze4_snoozing", int'(snoozing), 0);
    sw_in = 4'b0001; step("final_dismiss"); sw_in = 4'd0;
    check_val("final_dismiss_state", int'(state), S_DONE);

    // Alarm cleared while snoozing.
    do_reset();
    arm_and_ring(T);
    sw_in = 4'b0010; step("snz_press"); sw_in = 4'd0; step("snz_release");
    check_val("midsnz_state", int'(state), S_SNZ);
    bin_alarm = '0; step("alarm_clear");
    check_val("alarm_clear_mid_snooze", int'(state), S_IDLE);
    step("alarm_clear_out");
    check_val("alarm_clear_snoozing", int'(snoozing), 0);
`else
    do_reset();
    arm_and_ring(T);
    sw_in = 4'b0010; step("snz_press_disabled"); sw_in = 4'd0;
    repeat (3) step("snz_disabled");
    check_val("snooze_ignored_disabled", int'(state), S_RING);
    check_val("snoozing_tied_low", int'(snoozing), 0);
`endif

    // Randomized run against the model.
    do_reset();
    bin_alarm = 52'(10); bin_now = '0;
    for (int c = 0; c < 20000; c++) begin
      rst = ($urandom_range(0, 1999) != 0);
      if ($urandom_range(0, 2999) == 0) bin_alarm = 52'($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) bin_now = (bin_now + 52'($urandom_range(1, 2))) % 52'd64;
      tick_1s = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) sw_in = 4'($urandom_range(0, 3));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
